// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: command encodings and
// small decode helpers used by both the datapath and the control.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  // Multi-cycle commands: the ones that raise busy and commit later.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational signed/unsigned multiply and divide. Division works on
// magnitudes so truncation toward zero and MIN/-1 wrap fall out naturally.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  logic             mul_signed;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;

  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // The low 2*WIDTH bits of a product of sign-extended operands equal the
  // true signed product, so one multiplier serves both MULT and MULTU.
  always_comb begin
    mul_signed = (op == MD_MULT);
    a_ext      = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext      = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod       = a_ext * b_ext;
  end

  // |MIN| is representable as an unsigned magnitude, and negating a
  // quotient of 2^(WIDTH-1) wraps back to MIN, which gives MIN/-1 = MIN.
  always_comb begin
    div_signed = (op == MD_DIV);
    a_neg      = div_signed & a[WIDTH-1];
    b_neg      = div_signed & b[WIDTH-1];
    a_mag      = a_neg ? -a : a;
    b_mag      = b_neg ? -b : b;
    div_zero   = (b == '0);
    // Substitute a harmless divisor so a zero never reaches the divider.
    b_safe     = div_zero ? WIDTH'(1) : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
    res_hi = '0;
    res_lo = '0;
    case (op)
      MD_MULT, MD_MULTU: {res_hi, res_lo} = prod;
      MD_DIV, MD_DIVU: begin
        res_hi = rem;
        res_lo = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit: holds HI/LO, computes results at accept
// and commits them after a fixed per-operation latency while busy is high.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_dz;

  logic             accept;
  logic             load_pend;
  logic             commit;
  logic             write_hi;
  logic             write_lo;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;

  mdu_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op       (md_op),
    .a        (rs_val),
    .b        (rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // busy comes straight from the state flop, keeping the output registered.
  assign busy = (state_q == ST_BUSY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_pend = 1'b0;
    commit    = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept = start;
        if (start && is_muldiv(md_op)) begin
          state_d   = ST_BUSY;
          load_pend = 1'b1;
          cnt_d     = is_div(md_op) ? DIV_CNT : MULT_CNT;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Moves only land while idle; a start during busy is dropped entirely.
    write_hi = accept && (md_op == MD_MTHI);
    write_lo = accept && (md_op == MD_MTLO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_pend) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_dz <= is_div(md_op) && div_zero;
      end
    end
  end

  // A divide by zero still runs its full latency but leaves HI/LO untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (!pend_dz) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else begin
      if (write_hi) hi <= rs_val;
      if (write_lo) lo <= rs_val;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the driver queues expected HI/LO and busy
// length per multi-cycle op; a negedge monitor checks them on busy fall.
module tb_mdu_unit;

  localparam int W = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   md_op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] old_hi;
    logic [W-1:0] old_lo;
    int           cycles;
  } exp_t;

  exp_t         sb[$];
  int           tests;
  int           fails;
  logic [W-1:0] hi_m;
  logic [W-1:0] lo_m;

  mdu_unit #(
    .WIDTH       (W),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: first busy cycle checks HI/LO still hold old values; busy fall
  // pops the scoreboard and checks the committed values and busy length.
  int   busy_cnt;
  logic prev_busy;
  bit   held_checked;

  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt     = 0;
      prev_busy    = 1'b0;
      held_checked = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
        if (!held_checked && sb.size() > 0) begin
          check({sb[0].name, "_hold_hi"}, 64'(hi), 64'(sb[0].old_hi));
          check({sb[0].name, "_hold_lo"}, 64'(lo), 64'(sb[0].old_lo));
          held_checked = 1'b1;
        end
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          check("unexpected_commit", 64'(sb.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.cycles));
        end
        busy_cnt     = 0;
        held_checked = 1'b0;
      end
      prev_busy = busy;
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;
    start  = 1'b0;
    md_op  = 3'd0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) begin
      @(posedge clk); #1;
    end
    check("idle_bound", 64'(busy), 64'd0);
  endtask

  task automatic md(input string name, input logic [2:0] op, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                    input int n);
    exp_t e;
    e.name   = name;
    e.hi     = ehi;
    e.lo     = elo;
    e.old_hi = hi_m;
    e.old_lo = lo_m;
    e.cycles = n;
    sb.push_back(e);
    hi_m = ehi;
    lo_m = elo;
    issue(op, a, b);
    wait_idle(40);
  endtask

  task automatic mt(input string name, input logic [2:0] op, input logic [W-1:0] v);
    issue(op, v, '0);
    if (op == OP_MTHI) hi_m = v;
    else               lo_m = v;
    check({name, "_hi"}, 64'(hi), 64'(hi_m));
    check({name, "_lo"}, 64'(lo), 64'(lo_m));
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests  = 0;
    fails  = 0;
    hi_m   = '0;
    lo_m   = '0;
    reset  = 1'b0;
    start  = 1'b0;
    md_op  = 3'd0;
    rs_val = '0;
    rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    mt("mthi_aa", OP_MTHI, 32'h0000_00AA);
    mt("mtlo_bb", OP_MTLO, 32'h0000_00BB);

    // Reset in the middle of a MULT: cleared at once and nothing commits later.
    issue(OP_MULT, 32'd7, 32'd6);
    check("mult_inflight_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_hi", 64'(hi), 64'd0);
    check("async_reset_lo", 64'(lo), 64'd0);
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_hi", 64'(hi), 64'd0);
    check("post_reset_lo", 64'(lo), 64'd0);

    md("mult_neg2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    md("mult_negxneg", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F, 5);
    md("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    md("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    md("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    md("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 10);
    md("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 10);

    // Divide by zero: full busy period, HI/LO unchanged.
    mt("mthi_11", OP_MTHI, 32'h0000_0011);
    mt("mtlo_22", OP_MTLO, 32'h0000_0022);
    md("divu_by_zero", OP_DIVU, 32'd5, 32'd0, 32'h0000_0011, 32'h0000_0022, 10);
    md("div_by_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'h0000_0011, 32'h0000_0022, 10);

    // Start while busy is ignored; an MTLO right after busy drops lands.
    begin
      exp_t e;
      e.name   = "div_100_3_ignore_mtlo";
      e.hi     = 32'h0000_0001;
      e.lo     = 32'h0000_0021;
      e.old_hi = hi_m;
      e.old_lo = lo_m;
      e.cycles = 10;
      sb.push_back(e);
      hi_m = e.hi;
      lo_m = e.lo;
    end
    issue(OP_DIV, 32'd100, 32'd3);
    @(posedge clk); #1;
    issue(OP_MTLO, 32'h0000_0055, '0);
    check("mtlo_during_busy_lo", 64'(lo), 64'h22);
    check("mtlo_during_busy_busy", 64'(busy), 64'd1);
    wait_idle(40);
    mt("mtlo_after_busy", OP_MTLO, 32'h0000_0055);

    // NONE and reserved codes do nothing.
    issue(3'd0, 32'hDEAD_BEEF, 32'd1);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    check("noop_busy", 64'(busy), 64'd0);
    check("noop_hi", 64'(hi), 64'(hi_m));
    check("noop_lo", 64'(lo), 64'(lo_m));

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits beside the ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands, models a configurable latency, and holds `busy` so the hazard unit stalls later MD-class instructions.
- Generalised in operand width and per-operation latency.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU; must be >= 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be >= 1.
- CNT_W, 8, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe for the current EX instruction.
- md_op  in  3  command code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
- rs_val  in  WIDTH  first operand (dividend, or MTHI/MTLO source).
- rt_val  in  WIDTH  second operand (divisor / multiplier).
- busy  out  1  an operation is in flight.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.

Behaviour:
- Reset (reset=0, asynchronous): busy=0, hi=0, lo=0, cnt=0, pending registers=0. Any in-flight operation is discarded.
- Accept condition: start=1 && busy=0. A start while busy=1 is ignored entirely; the hazard unit never issues one.
- MTHI/MTLO on accept: hi (or lo) <= rs_val at that edge. busy stays 0. The new value is visible the next cycle.
- MULT/MULTU on accept:
  - Full 2*WIDTH product (signed or unsigned) latched into pend_hi/pend_lo.
  - cnt <= MULT_CYCLES, busy <= 1.
- DIV/DIVU on accept:
  - pend_lo = quotient, pend_hi = remainder.
  - cnt <= DIV_CYCLES, busy <= 1.
- Each edge while busy=1: cnt <= cnt-1. When cnt==1 at the edge: hi<=pend_hi, lo<=pend_lo, busy<=0.
- Resulting timing: busy is high for exactly N cycles after the accept edge. hi/lo hold their old values throughout and show the new result in the first cycle busy=0.
- Signed division:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Most-negative / -1 gives quotient = most-negative (wrap) and remainder = 0.
- Divide by zero (rt_val=0, DIV or DIVU): full DIV_CYCLES busy period still runs; hi/lo are left unchanged at commit.
- md_op NONE or 7 with start=1: no effect.
- Outputs are registered only; no combinational path from inputs to busy, hi or lo.
- Hazard unit stalls when (busy || start&&md_op in 1..4) and the ID instruction is MD-class. That is external logic, not part of this block.

Decomposition:
- Package mdu_pkg: md_op encodings as named constants (MD_NONE..MD_MTLO) and an is_muldiv(op) helper function.
- One combinational sub-module, mdu_arith: WIDTH-parametrised signed/unsigned multiply and divide. Outputs res_hi, res_lo, div_zero.
- mdu_unit itself owns the counter, busy, pending and HI/LO registers.

Test Plan:
- Reset mid-operation: start MULT of 7 and 6, pull reset low two cycles later → busy=0, hi=0, lo=0 immediately (asynchronously); no commit after reset is released.
- MULT signed: rs=0xFFFFFFFE (-2), rt=3 → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. hi/lo keep their old values during busy.
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV signed:
  - rs=-7, rt=2 → after 10 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - rs=0x80000000, rt=-1 → lo=0x80000000, hi=0.
- DIVU by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO → busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- Start while busy: during a DIV, pulse start with MTLO rs=0x55 → ignored; lo ends as the quotient. MTLO issued the cycle after busy drops → lo=0x55 the following cycle.
